md_seq_ctrl: RTL and testbench



---
 rtl/md_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_md_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: sequences the iterative multiply/divide unit feeding XM.
// Detects a mult/div R-type in DX, fires a one-cycle start pulse, holds
// FD/DX with XM bubbles until the unit is ready (or a timeout fires), then
// releases the instruction for one cycle with the result override asserted.
//
// Ports:
//   rise          clock, rising edge
//   reset         asynchronous active-high reset
//   opcode_dx     DX instruction [31:27]
//   aluop_dx      DX instruction [6:2]
//   flush         taken branch/jump squashes DX
//   stall_xm      downstream hold of XM register
//   md_rdy        unit result ready
//   md_exception  unit overflow/div-by-zero, valid with md_rdy
//   ctrl_mult     start-multiply pulse
//   ctrl_div      start-divide pulse
//   stall_dx      freeze PC/FD/DX
//   bubble_xm     load a nop into XM
//   md_sel        XM takes the unit result
//   md_ovf        overflow into XM override
//   md_busy       operation in flight (ISSUE or WAIT)
//   md_timeout    sticky timeout flag, cleared only by reset
module md_seq_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 6
) (
    input  logic       rise,
    input  logic       reset,
    input  logic [4:0] opcode_dx,
    input  logic [4:0] aluop_dx,
    input  logic       flush,
    input  logic       stall_xm,
    input  logic       md_rdy,
    input  logic       md_exception,
    output logic       ctrl_mult,
    output logic       ctrl_div,
    output logic       stall_dx,
    output logic       bubble_xm,
    output logic       md_sel,
    output logic       md_ovf,
    output logic       md_busy,
    output logic       md_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          op_q, op_d;
    logic          exc_q, exc_d;
    logic          timeout_d;
    logic          md_op;

    // mul = 00110, div = 00111 under the R-type opcode
    assign md_op = (opcode_dx == 5'b00000) &&
                   ((aluop_dx == 5'b00110) || (aluop_dx == 5'b00111));

    // State and context registers
    always_ff @(posedge rise or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= 1'b0;
            exc_q      <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            op_q       <= op_d;
            exc_q      <= exc_d;
            md_timeout <= timeout_d;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        op_d      = op_q;
        exc_d     = exc_q;
        timeout_d = md_timeout;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall_dx  = 1'b0;
        bubble_xm = 1'b0;
        md_sel    = 1'b0;
        md_ovf    = 1'b0;
        md_busy   = 1'b0;

        unique case (state)
            IDLE: begin
                // Detect outputs are combinational; gate them so an asserted
                // reset forces every output low immediately.
                if (md_op && !flush && !reset) begin
                    stall_dx  = 1'b1;
                    bubble_xm = 1'b1;
                    op_d      = aluop_dx[0];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Start pulse fires even if this cycle is flushed
                ctrl_mult = ~op_q;
                ctrl_div  = op_q;
                stall_dx  = 1'b1;
                bubble_xm = 1'b1;
                md_busy   = 1'b1;
                cnt_d     = '0;
                if (flush) begin
                    exc_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_dx  = 1'b1;
                bubble_xm = 1'b1;
                md_busy   = 1'b1;
                if (flush) begin
                    exc_d   = 1'b0;
                    state_d = IDLE;
                end else if (md_rdy) begin
                    exc_d   = md_exception;
                    state_d = DONE;
                end else if (cnt == CNT_LAST) begin
                    exc_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                md_sel = 1'b1;
                md_ovf = exc_q;
                if (!stall_xm) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Testbench for md_seq_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_md_seq_ctrl;

    localparam int unsigned TIMEOUT = 40;

    logic       rise = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] opcode_dx = '0;
    logic [4:0] aluop_dx = '0;
    logic       flush = 1'b0;
    logic       stall_xm = 1'b0;
    logic       md_rdy = 1'b0;
    logic       md_exception = 1'b0;
    logic       ctrl_mult, ctrl_div, stall_dx, bubble_xm;
    logic       md_sel, md_ovf, md_busy, md_timeout;

    int checks = 0;
    int errors = 0;

    md_seq_ctrl #(.TIMEOUT(TIMEOUT), .CW(6)) dut (
        .rise(rise), .reset(reset), .opcode_dx(opcode_dx), .aluop_dx(aluop_dx),
        .flush(flush), .stall_xm(stall_xm), .md_rdy(md_rdy),
        .md_exception(md_exception), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .stall_dx(stall_dx), .bubble_xm(bubble_xm), .md_sel(md_sel),
        .md_ovf(md_ovf), .md_busy(md_busy), .md_timeout(md_timeout)
    );

    always #5 rise = ~rise;

    typedef struct {
        logic [4:0] op;
        logic [4:0] alu;
        logic       fl, sx, rdy, exc;
        logic [7:0] exp;
    } vec_t;

    // Output vector order: mult, div, stall, bubble, sel, ovf, busy, timeout
    function automatic logic [7:0] ev(input logic m, d, st, se, ov, bu, to);
        return {m, d, st, st, se, ov, bu, to};
    endfunction

    function automatic logic [7:0] outs();
        return {ctrl_mult, ctrl_div, stall_dx, bubble_xm, md_sel, md_ovf, md_busy, md_timeout};
    endfunction

    function automatic vec_t mk(input logic [4:0] op, alu, input logic fl, sx, rdy, exc,
                                input logic [7:0] exp);
        vec_t v;
        v.op = op; v.alu = alu; v.fl = fl; v.sx = sx; v.rdy = rdy; v.exc = exc; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [4:0] op, alu, input logic fl, sx, rdy, exc);
        opcode_dx = op; aluop_dx = alu; flush = fl; stall_xm = sx;
        md_rdy = rdy; md_exception = exc;
    endtask

    task automatic step();
        @(posedge rise);
        #1;
    endtask

    task automatic do_reset();
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Reference model: tracks the age of the operation in flight instead of
    // a state encoding. age -1 = nothing in flight, 0 = start cycle,
    // 1..TIMEOUT = wait cycle index.
    int   m_age;
    bit   m_done, m_div, m_ovf, m_sticky;

    function automatic logic [7:0] model_out(input logic [4:0] op, alu, input logic fl);
        bit mdop;
        mdop = (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
        if (m_done)       return ev(0, 0, 0, 1, m_ovf, 0, m_sticky);
        if (m_age == 0)   return ev(!m_div, m_div, 1, 0, 0, 1, m_sticky);
        if (m_age > 0)    return ev(0, 0, 1, 0, 0, 1, m_sticky);
        if (mdop && !fl)  return ev(0, 0, 1, 0, 0, 0, m_sticky);
        return ev(0, 0, 0, 0, 0, 0, m_sticky);
    endfunction

    task automatic model_step(input logic [4:0] op, alu, input logic fl, sx, rdy, exc);
        bit mdop;
        mdop = (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
        if (m_done) begin
            if (!sx) m_done = 0;
        end else if (m_age >= 0) begin
            if (fl) m_age = -1;
            else if (m_age >= 1 && rdy) begin
                m_done = 1; m_ovf = exc; m_age = -1;
            end else if (m_age == int'(TIMEOUT)) begin
                m_done = 1; m_ovf = 1; m_sticky = 1; m_age = -1;
            end else m_age++;
        end else if (mdop && !fl) begin
            m_age = 0; m_div = alu[0];
        end
    endtask

    vec_t tbl[23];
    int   n;
    int   pulses;
    logic [4:0] r_op, r_alu;
    logic r_fl, r_sx, r_rdy, r_exc;

    initial begin
        // Reset with a mul present in DX: everything must be low
        set_in(5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge rise);
        chk("reset_state", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
        step();
        reset = 1'b0;

        tbl[0]  = mk(0, 6, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0));
        tbl[1]  = mk(0, 6, 0, 0, 0, 0, ev(1, 0, 1, 0, 0, 1, 0));
        tbl[2]  = mk(0, 6, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 1, 0));
        tbl[3]  = mk(0, 6, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 1, 0));
        tbl[4]  = mk(0, 6, 0, 0, 1, 0, ev(0, 0, 1, 0, 0, 1, 0));
        tbl[5]  = mk(0, 6, 0, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 0));
        tbl[6]  = mk(8, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0));
        tbl[7]  = mk(0, 7, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0));
        tbl[8]  = mk(0, 7, 0, 0, 1, 0, ev(0, 1, 1, 0, 0, 1, 0));
        tbl[9]  = mk(0, 7, 0, 0, 1, 1, ev(0, 0, 1, 0, 0, 1, 0));
        tbl[10] = mk(0, 7, 0, 1, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
        tbl[11] = mk(0, 7, 1, 1, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
        tbl[12] = mk(0, 7, 0, 1, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
        tbl[13] = mk(0, 7, 0, 0, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
        tbl[14] = mk(0, 7, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0));
        tbl[15] = mk(0, 7, 0, 0, 0, 0, ev(0, 1, 1, 0, 0, 1, 0));
        tbl[16] = mk(0, 7, 1, 0, 0, 0, ev(0, 0, 1, 0, 0, 1, 0));
        tbl[17] = mk(0, 6, 1, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0));
        tbl[18] = mk(1, 6, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0));
        tbl[19] = mk(0, 5, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0));
        tbl[20] = mk(0, 6, 0, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0));
        tbl[21] = mk(0, 6, 1, 0, 0, 0, ev(1, 0, 1, 0, 0, 1, 0));
        tbl[22] = mk(8, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            set_in(tbl[i].op, tbl[i].alu, tbl[i].fl, tbl[i].sx, tbl[i].rdy, tbl[i].exc);
            @(negedge rise);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            step();
        end

        // Div by zero: ready with exception on the 32nd wait cycle
        pulses = 0;
        set_in(0, 7, 0, 0, 0, 0);
        @(negedge rise); chk("div_detect", 32'(outs()), 32'(ev(0, 0, 1, 0, 0, 0, 0))); step();
        for (int w = 0; w <= 32; w++) begin
            set_in(0, 7, 0, 0, w == 32, w == 32);
            @(negedge rise);
            pulses += int'(ctrl_div);
            if (ctrl_mult) pulses += 100;
            if (w > 0) chk("div_wait", 32'(outs()), 32'(ev(0, 0, 1, 0, 0, 1, 0)));
            step();
        end
        chk("div_pulses", 32'(pulses), 32'd1);
        set_in(8, 0, 0, 0, 0, 0);
        @(negedge rise); chk("div_done", 32'(outs()), 32'(ev(0, 0, 0, 1, 1, 0, 0))); step();
        @(negedge rise); chk("div_idle", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
        step();

        // Timeout: mul never gets ready
        set_in(0, 6, 0, 0, 0, 0);
        step(); step();
        n = 0;
        while (n < 100) begin
            @(negedge rise);
            if (md_sel) break;
            n++;
            step();
        end
        chk("timeout_waits", 32'(n), 32'(TIMEOUT));
        chk("timeout_done", 32'(outs()), 32'(ev(0, 0, 0, 1, 1, 0, 1)));
        step();
        // Follow-up mul with clean result: flag stays sticky, ovf clear
        set_in(0, 6, 0, 0, 0, 0); step(); step();
        set_in(0, 6, 0, 0, 1, 0); step();
        set_in(8, 0, 0, 0, 0, 0);
        @(negedge rise); chk("sticky_timeout", 32'(outs()), 32'(ev(0, 0, 0, 1, 0, 0, 1)));
        step();

        // Flush at wait cycle 5, late ready two cycles later
        set_in(0, 6, 0, 0, 0, 0); step(); step();
        for (int w = 1; w <= 4; w++) step();
        set_in(0, 6, 1, 0, 0, 0);
        @(negedge rise); chk("flush_wait", 32'(outs()), 32'(ev(0, 0, 1, 0, 0, 1, 1))); step();
        for (int k = 0; k < 3; k++) begin
            set_in(8, 0, 0, 0, k == 1, k == 1);
            @(negedge rise);
            chk($sformatf("after_flush%0d", k), 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 1)));
            step();
        end

        // Asynchronous reset between edges in WAIT
        set_in(0, 6, 0, 0, 0, 0); step(); step(); step(); step();
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 0)));
        step();
        reset = 1'b0;
        @(negedge rise); chk("rst_redetect", 32'(outs()), 32'(ev(0, 0, 1, 0, 0, 0, 0))); step();
        @(negedge rise); chk("rst_reissue", 32'(outs()), 32'(ev(1, 0, 1, 0, 0, 1, 0))); step();

        // Randomized traffic against the reference model
        do_reset();
        m_age = -1; m_done = 0; m_div = 0; m_ovf = 0; m_sticky = 0;
        for (int c = 0; c < 3000; c++) begin
            r_op  = ($urandom_range(0, 9) < 8) ? 5'd0 : 5'($urandom_range(1, 31));
            case ($urandom_range(0, 3))
                0, 1:    r_alu = 5'd6;
                2:       r_alu = 5'd7;
                default: r_alu = 5'($urandom_range(0, 31));
            endcase
            r_fl  = ($urandom_range(0, 99) < 6);
            r_sx  = ($urandom_range(0, 99) < 30);
            r_rdy = ($urandom_range(0, 99) < 15);
            r_exc = 1'($urandom_range(0, 1));
            set_in(r_op, r_alu, r_fl, r_sx, r_rdy, r_exc);
            @(negedge rise);
            chk("random", 32'(outs()), 32'(model_out(r_op, r_alu, r_fl)));
            model_step(r_op, r_alu, r_fl, r_sx, r_rdy, r_exc);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
